// File: rtl/bkm_steps_stream_driver.sv
// bkm_steps_stream_driver: buffered, handshaked operand source for bkm_steps.
// Binary operand vectors are queued in a DEPTH-entry FIFO. A single output
// register stage presents them as CSD data operands plus binary control
// operands under out_valid/out_ready.
// Optional feature macro: BKM_DRV_CNT_EN adds an internal counter source
// selected by src_sel=0. Without it, src_sel is ignored and the FIFO is the
// only source.

// Non-adjacent-form recoder: digit i is {csd[2i+1]=negative, csd[2i]=positive}.
// The input is treated as two's complement, so W digits always suffice.
module bin2csd #(
    parameter int W = 8
) (
    input  logic [W-1:0]   bin,
    output logic [2*W-1:0] csd
);
    logic [W:0] ext_s;
    logic       carry_s;

    assign ext_s = {bin[W-1], bin};

    // Ripple NAF recoding: an odd partial sum becomes -1 when the next bit is
    // set (carry forward), otherwise +1.
    always_comb begin
        csd     = '0;
        carry_s = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (bin[i] ^ carry_s) begin
                if (ext_s[i+1]) begin
                    csd[2*i+1] = 1'b1;
                    carry_s    = 1'b1;
                end else begin
                    csd[2*i]   = 1'b1;
                    carry_s    = 1'b0;
                end
            end else begin
                carry_s = bin[i] & carry_s;
            end
        end
    end
endmodule

module bkm_steps_stream_driver #(
    parameter  int WD    = 72,
    parameter  int WC    = 21,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            srst,
    input  logic            enable,
    input  logic            src_sel,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [WD-1:0]   X_in_bin,
    input  logic [WD-1:0]   Y_in_bin,
    input  logic [WC-1:0]   u_in_bin,
    input  logic [WC-1:0]   v_in_bin,
    output logic [2*WD-1:0] X_out_csd,
    output logic [2*WD-1:0] Y_out_csd,
    output logic [WC-1:0]   u_out_bin,
    output logic [WC-1:0]   v_out_bin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW:0]     fifo_level
);
    localparam int VW = 2*WD + 2*WC;

    logic [VW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   level_r;
    logic [WD-1:0] x_r;
    logic [WD-1:0] y_r;
    logic [WC-1:0] u_r;
    logic [WC-1:0] v_r;
    logic          out_valid_r;

    logic          push_s;
    logic          pop_s;
    logic          load_s;
    logic          fifo_mode_s;
    logic          src_avail_s;
    logic          in_ready_s;
    logic [VW-1:0] head_s;
    logic [VW-1:0] new_vec_s;

`ifdef BKM_DRV_CNT_EN
    logic [WD-1:0] cnt_r;
    assign fifo_mode_s = src_sel;
`else
    logic          unused_src_sel_s;
    assign unused_src_sel_s = src_sel;
    assign fifo_mode_s      = 1'b1;
`endif

    // in_ready is forced low while either reset is asserted.
    assign in_ready_s  = enable & ~arst & ~srst & (level_r != (AW+1)'(DEPTH));
    assign push_s      = in_valid & in_ready_s;
    assign src_avail_s = fifo_mode_s ? (level_r != '0) : 1'b1;
    assign load_s      = enable & (~out_valid_r | out_ready) & src_avail_s;
    assign pop_s       = load_s & fifo_mode_s;
    assign head_s      = mem_r[rd_ptr_r];

    // Select the vector entering the output stage on load.
    always_comb begin
        new_vec_s = head_s;
`ifdef BKM_DRV_CNT_EN
        if (!fifo_mode_s) begin
            new_vec_s = {cnt_r, ~cnt_r, cnt_r[WC-1:0], cnt_r[WC-1:0]};
        end else begin
            new_vec_s = head_s;
        end
`endif
    end

    // FIFO storage; contents are only meaningful below fifo_level, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {X_in_bin, Y_in_bin, u_in_bin, v_in_bin};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the level.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (srst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + 1'b1;
                2'b01:   level_r <= level_r - 1'b1;
                default: level_r <= level_r;
            endcase
        end
    end

    // Output stage: load when empty or accepted, drop valid on accept-only,
    // otherwise hold data unchanged.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            x_r         <= '0;
            y_r         <= '0;
            u_r         <= '0;
            v_r         <= '0;
            out_valid_r <= 1'b0;
        end else if (srst) begin
            x_r         <= '0;
            y_r         <= '0;
            u_r         <= '0;
            v_r         <= '0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            {x_r, y_r, u_r, v_r} <= new_vec_s;
            out_valid_r          <= 1'b1;
        end else if (enable && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

`ifdef BKM_DRV_CNT_EN
    // Counter source advances once per counter-mode load, wrapping naturally.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt_r <= '0;
        end else if (srst) begin
            cnt_r <= '0;
        end else if (load_s && !fifo_mode_s) begin
            cnt_r <= cnt_r + 1'b1;
        end
    end
`endif

    bin2csd #(.W(WD)) u_csd_x (.bin(x_r), .csd(X_out_csd));
    bin2csd #(.W(WD)) u_csd_y (.bin(y_r), .csd(Y_out_csd));

    assign u_out_bin  = u_r;
    assign v_out_bin  = v_r;
    assign out_valid  = out_valid_r;
    assign in_ready   = in_ready_s;
    assign fifo_level = level_r;
endmodule

// File: tb/tb_bkm_steps_stream_driver.sv
// Scoreboard bench for bkm_steps_stream_driver (WD=8, WC=4, DEPTH=8).
// Accepted pushes enqueue the expected vector; a negedge monitor pops and
// compares on every out_valid & out_ready transfer.
module tb_bkm_steps_stream_driver;
    localparam int WD    = 8;
    localparam int WC    = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct packed {
        logic [WD-1:0] x;
        logic [WD-1:0] y;
        logic [WC-1:0] u;
        logic [WC-1:0] v;
    } vec_t;

    logic            clk = 1'b0;
    logic            arst, srst, enable, src_sel, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [WD-1:0]   X_in_bin, Y_in_bin;
    logic [WC-1:0]   u_in_bin, v_in_bin;
    logic [2*WD-1:0] X_out_csd, Y_out_csd;
    logic [WC-1:0]   u_out_bin, v_out_bin;
    logic [AW:0]     fifo_level;

    vec_t exp_q[$];
    vec_t mon_e;
    int   n_tests    = 0;
    int   n_fail     = 0;
    int   xfer_count = 0;

    bkm_steps_stream_driver #(.WD(WD), .WC(WC), .DEPTH(DEPTH)) dut (
        .clk(clk), .arst(arst), .srst(srst), .enable(enable), .src_sel(src_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .X_in_bin(X_in_bin), .Y_in_bin(Y_in_bin),
        .u_in_bin(u_in_bin), .v_in_bin(v_in_bin),
        .X_out_csd(X_out_csd), .Y_out_csd(Y_out_csd),
        .u_out_bin(u_out_bin), .v_out_bin(v_out_bin),
        .out_valid(out_valid), .out_ready(out_ready), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Reference NAF via the 3x trick: digits come from (3x ^ x) >> 1.
    function automatic logic [2*WD-1:0] csd_ref(input logic [WD-1:0] x);
        logic [WD+1:0]   xs, t, np;
        logic [2*WD-1:0] r;
        xs = {{2{x[WD-1]}}, x};
        t  = xs + (xs << 1);
        np = t ^ xs;
        r  = '0;
        for (int i = 0; i < WD; i++) begin
            r[2*i]   = t[i+1]  & np[i+1];
            r[2*i+1] = xs[i+1] & np[i+1];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; holds in_valid until accepted, returns at posedge+1.
    task automatic push_vec(input logic [WD-1:0] x, input logic [WD-1:0] y,
                            input logic [WC-1:0] u, input logic [WC-1:0] v);
        int   guard;
        logic acc;
        vec_t e;
        guard    = 0;
        acc      = 1'b0;
        e        = {x, y, u, v};
        in_valid = 1'b1;
        X_in_bin = x;
        Y_in_bin = y;
        u_in_bin = u;
        v_in_bin = v;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) exp_q.push_back(e);
            @(posedge clk);
            #1;
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: vector %0h not accepted, required acceptance", x);
        end
    endtask

    task automatic push_num(input int n);
        logic [WD-1:0] xv;
        xv = WD'(n);
        push_vec(xv, -xv, xv[WC-1:0], xv[WC-1:0]);
    endtask

    task automatic wait_empty(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            tick(1);
            g++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a transfer happens at the next posedge when these hold now.
    always @(negedge clk) begin
        if (!arst && !srst && enable && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got X_out_csd=%0h, required no output", X_out_csd);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_vec", 64'({X_out_csd, Y_out_csd, u_out_bin, v_out_bin}),
                      64'({csd_ref(mon_e.x), csd_ref(mon_e.y), mon_e.u, mon_e.v}));
            end
            xfer_count++;
        end
    end

    initial begin
        arst = 1'b1; srst = 1'b0; enable = 1'b1; src_sel = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        X_in_bin = '0; Y_in_bin = '0; u_in_bin = '0; v_in_bin = '0;
        tick(2);

        // Reset values
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_x_csd", 64'(X_out_csd), 64'd0);
        check("rst_y_csd", 64'(Y_out_csd), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        arst = 1'b0;
        #1;
        check("rel_in_ready", 64'(in_ready), 64'd1);
        tick(1);

        // Latency and ordering: 1,2,3 with out_ready=1
        out_ready = 1'b1;
        fork
            begin
                push_num(1);
                push_num(2);
                push_num(3);
            end
            begin
                logic exp_ov [6];
                exp_ov = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
                for (int k = 0; k < 6; k++) begin
                    @(negedge clk);
                    check($sformatf("lat_ov_c%0d", k), 64'(out_valid), 64'(exp_ov[k]));
                end
            end
        join
        wait_empty("lat_drain");
        tick(1);

        // Asynchronous reset mid-cycle with three vectors queued
        out_ready = 1'b0;
        push_num(10);
        push_num(11);
        push_num(12);
        check("pre_rst_level", 64'(fifo_level), 64'd2);
        @(negedge clk);
        #1;
        arst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_level", 64'(fifo_level), 64'd0);
        check("arst_x_csd", 64'(X_out_csd), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        arst = 1'b0;
        out_ready = 1'b1;
        tick(5);
        check("post_rst_no_stale", 64'(out_valid), 64'd0);

        // Full and backpressure, then push+pop at DEPTH-1
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_num(20 + i);
        check("full_level", 64'(fifo_level), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_head", 64'(X_out_csd), 64'(csd_ref(8'd20)));
        tick(2);
        check("hold_head", 64'(X_out_csd), 64'(csd_ref(8'd20)));
        fork
            begin
                out_ready = 1'b1;
                for (int k = 0; k < 5; k++) push_num(40 + k);
            end
            begin
                @(negedge clk);
                check("pp_full_level", 64'(fifo_level), 64'd8);
                check("pp_full_ready", 64'(in_ready), 64'd0);
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check($sformatf("pp_level_c%0d", k), 64'(fifo_level), 64'd7);
                    check($sformatf("pp_ready_c%0d", k), 64'(in_ready), 64'd1);
                end
            end
        join
        wait_empty("full_drain");
        tick(2);
        check("full_drained_ov", 64'(out_valid), 64'd0);
        check("full_drained_lvl", 64'(fifo_level), 64'd0);

        // enable=0 freeze with out_valid=1 and out_ready=1
        out_ready = 1'b0;
        push_num(60);
        push_num(61);
        push_num(62);
        out_ready = 1'b1;
        enable    = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("frz_ov_c%0d", k), 64'(out_valid), 64'd1);
            check($sformatf("frz_x_c%0d", k), 64'(X_out_csd), 64'(csd_ref(8'd60)));
            check($sformatf("frz_lvl_c%0d", k), 64'(fifo_level), 64'd2);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        wait_empty("frz_drain");
        tick(1);

        // Synchronous reset clears held and queued vectors
        out_ready = 1'b0;
        push_num(70);
        push_num(71);
        srst = 1'b1;
        #1;
        check("srst_in_ready", 64'(in_ready), 64'd0);
        tick(1);
        srst = 1'b0;
        exp_q.delete();
        check("srst_out_valid", 64'(out_valid), 64'd0);
        check("srst_level", 64'(fifo_level), 64'd0);
        check("srst_y_csd", 64'(Y_out_csd), 64'd0);

`ifdef BKM_DRV_CNT_EN
        // Counter source: X=cnt, Y=~cnt, u=v=cnt[3:0], through the 255->0 wrap
        begin
            int target;
            int g;
            logic [WD-1:0] cv;
            vec_t e;
            src_sel = 1'b0;
            for (int i = 0; i < 260; i++) begin
                cv = WD'(i % 256);
                e  = {cv, ~cv, cv[WC-1:0], cv[WC-1:0]};
                exp_q.push_back(e);
            end
            tick(1);
            check("cnt_first_ov", 64'(out_valid), 64'd1);
            check("cnt_first_x", 64'(X_out_csd), 64'(csd_ref(8'd0)));
            target    = xfer_count + 260;
            out_ready = 1'b1;
            g = 0;
            while (xfer_count < target && g < 400) begin
                @(negedge clk);
                #1;
                g++;
            end
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("cnt_all_seen", 64'(exp_q.size()), 64'd0);
            tick(1);
            check("cnt_held_x", 64'(X_out_csd), 64'(csd_ref(8'd4)));
            srst = 1'b1;
            tick(1);
            srst    = 1'b0;
            src_sel = 1'b1;
            exp_q.delete();
        end
`endif

        tick(3);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
